temp_led_bargraph: RTL and testbench

Registered, parametrised temperature-to-LED bar graph driven by ADC samples.
- Averages 2^AVG_LOG2 ADC samples and compares the average against a runtime-writable threshold table.
- Applies hysteresis on cooling, then drives the board LED array.
- Blinks the LED array and raises an alarm at the hottest level.
- Sits between the ADC sampling interface and the top-level LED pins.

---
 rtl/temp_led_pkg.sv | 32 +++
 rtl/temp_led_avg.sv | 48 ++++
 rtl/temp_led_bargraph.sv | 109 ++++++++++
 tb/tb_temp_led_bargraph.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/temp_led_pkg.sv
// Shared constants and helpers for the temperature LED bar graph.
// Default thresholds run from 80 C down to 30 C; a lower ADC count means hotter.
package temp_led_pkg;

  localparam int LED_MAX = 64;

  function automatic logic [31:0] thr_default(input int idx);
    case (idx)
      0:       return 32'd3550;
      1:       return 32'd3576;
      2:       return 32'd3595;
      3:       return 32'd3625;
      4:       return 32'd3643;
      5:       return 32'd3666;
      default: return '1;
    endcase
  endfunction

  // Build the bar pattern.
  // The top (led_w-num_lvl) bits are always lit.
  // `lvl` ones then fill downward from bit num_lvl-1.
  function automatic logic [LED_MAX-1:0] bar_pattern(input int lvl, input int led_w,
                                                     input int num_lvl);
    logic [LED_MAX-1:0] p;
    p = '0;
    for (int i = 0; i < LED_MAX; i++) begin
      if (i < led_w && i >= num_lvl - lvl) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/temp_led_avg.sv
// Boxcar averager: sums 2^AVG_LOG2 valid samples.
// Publishes the truncated mean together with a one-cycle strobe.
module temp_led_avg #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_dout,
  output logic [ADC_W-1:0] avg_out,
  output logic             avg_vld
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign sum  = acc + ACC_W'(adc_dout);
  assign last = (cnt == CNT_W'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      avg_out <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (adc_valid) begin
        if (last) begin
          avg_out <= ADC_W'(sum >> AVG_LOG2);
          avg_vld <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/temp_led_bargraph.sv
// Temperature bar graph: averaged ADC samples are mapped to a heat level with
// cooling hysteresis, then shown on the LED array; the hottest level blinks.
module temp_led_bargraph
  import temp_led_pkg::*;
#(
  parameter int ADC_W     = 12,
  parameter int LED_W     = 8,
  parameter int NUM_LVL   = 6,
  parameter int AVG_LOG2  = 2,
  parameter int HYST      = 4,
  parameter int BLINK_DIV = 25000000,
  localparam int IDX_W    = (NUM_LVL > 1) ? $clog2(NUM_LVL) : 1,
  localparam int LVL_W    = $clog2(NUM_LVL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_dout,
  input  logic             thr_we,
  input  logic [IDX_W-1:0] thr_idx,
  input  logic [ADC_W-1:0] thr_data,
  output logic [LED_W-1:0] led,
  output logic [LVL_W-1:0] level,
  output logic [ADC_W-1:0] avg_out,
  output logic             alarm
);

  localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic             avg_vld;
  logic [ADC_W-1:0] thr [NUM_LVL];
  logic [ADC_W-1:0] avg_h;
  logic [LVL_W-1:0] cand, dn;
  logic [LED_W-1:0] led_bar;
  logic             alarm_nxt, phase, phase_nxt;
  logic [BC_W-1:0]  blink_cnt, cnt_nxt;

  temp_led_avg #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk      (clk),
    .rst      (rst),
    .adc_valid(adc_valid),
    .adc_dout (adc_dout),
    .avg_out  (avg_out),
    .avg_vld  (avg_vld)
  );

  // Writes land at the edge, so a write during avg_vld cannot affect that comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LVL; i++)
        thr[i] <= (i < 6) ? ADC_W'(thr_default(i)) : '1;
    end else if (thr_we && int'(thr_idx) < NUM_LVL) begin
      thr[thr_idx] <= thr_data;
    end
  end

  always_comb begin
    cand  = '0;
    dn    = '0;
    avg_h = (avg_out >= ADC_W'(HYST)) ? avg_out - ADC_W'(HYST) : '0;
    for (int i = 0; i < NUM_LVL; i++) begin
      if (avg_out <= thr[i]) cand = cand + LVL_W'(1);
      if (avg_h <= thr[i])   dn   = dn + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (avg_vld) begin
      if (cand > level)   level <= cand;
      else if (dn < level) level <= dn;
    end
  end

  assign led_bar   = LED_W'(bar_pattern(int'(level), LED_W, NUM_LVL));
  assign alarm_nxt = (level == LVL_W'(NUM_LVL));

  // Entering alarm always starts with the array lit and a fresh half-period.
  always_comb begin
    phase_nxt = 1'b0;
    cnt_nxt   = '0;
    if (alarm_nxt) begin
      if (!alarm) begin
        phase_nxt = 1'b1;
      end else if (blink_cnt == BC_W'(BLINK_DIV - 1)) begin
        phase_nxt = ~phase;
      end else begin
        phase_nxt = phase;
        cnt_nxt   = blink_cnt + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= LED_W'(bar_pattern(0, LED_W, NUM_LVL));
      alarm     <= 1'b0;
      phase     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      led       <= alarm_nxt ? {LED_W{phase_nxt}} : led_bar;
      alarm     <= alarm_nxt;
      phase     <= phase_nxt;
      blink_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_temp_led_bargraph.sv
// Directed bench for temp_led_bargraph with hand-computed levels and LED patterns.
module tb_temp_led_bargraph;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_dout = '0;
  logic        thr_we = 1'b0;
  logic [2:0]  thr_idx = '0;
  logic [11:0] thr_data = '0;
  logic [7:0]  led;
  logic [2:0]  level;
  logic [11:0] avg_out;
  logic        alarm;

  int checks = 0;
  int errors = 0;

  temp_led_bargraph #(
    .ADC_W(12), .LED_W(8), .NUM_LVL(6), .AVG_LOG2(2), .HYST(4), .BLINK_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .adc_valid(adc_valid),
    .adc_dout (adc_dout),
    .thr_we   (thr_we),
    .thr_idx  (thr_idx),
    .thr_data (thr_data),
    .led      (led),
    .level    (level),
    .avg_out  (avg_out),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] s);
    adc_valid = 1'b1;
    adc_dout  = s;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic feedFour(input logic [11:0] s0, input logic [11:0] s1,
                          input logic [11:0] s2, input logic [11:0] s3);
    applyStimulus(s0);
    applyStimulus(s1);
    applyStimulus(s2);
    applyStimulus(s3);
  endtask

  task automatic writeThr(input logic [2:0] idx, input logic [11:0] data);
    thr_we   = 1'b1;
    thr_idx  = idx;
    thr_data = data;
    tick();
    thr_we = 1'b0;
  endtask

  initial begin
    // Reset and idle stability
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_led", led, 8'hC0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_alarm", alarm, 0);
    checkOutput("rst_avg", avg_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_led", led, 8'hC0);
      checkOutput("idle_level", level, 0);
      checkOutput("idle_avg", avg_out, 0);
    end

    // Averaging and pipeline latency
    feedFour(3600, 3600, 3600, 3600);
    checkOutput("lat_avg", avg_out, 3600);
    checkOutput("lat_level_early", level, 0);
    tick();
    checkOutput("lat_level", level, 3);
    checkOutput("lat_led_early", led, 8'hC0);
    tick();
    checkOutput("lat_led", led, 8'hF8);

    // Hysteresis holds, then cooling past the margin drops a level
    feedFour(3627, 3627, 3627, 3627);
    tick();
    tick();
    checkOutput("hyst_hold_level", level, 3);
    checkOutput("hyst_hold_led", led, 8'hF8);
    feedFour(3630, 3630, 3630, 3630);
    tick();
    tick();
    checkOutput("hyst_drop_level", level, 2);
    checkOutput("hyst_drop_led", led, 8'hF0);

    // Alarm blinking with a 4-cycle half-period
    feedFour(3540, 3540, 3560, 3560);
    checkOutput("alarm_avg", avg_out, 3550);
    tick();
    checkOutput("alarm_level", level, 6);
    tick();
    checkOutput("alarm_flag", alarm, 1);
    for (int k = 0; k < 12; k++) begin
      checkOutput("blink_led", led, (((k / 4) % 2) == 0) ? 8'hFF : 8'h00);
      tick();
    end
    feedFour(3700, 3700, 3700, 3700);
    tick();
    checkOutput("cool_level", level, 0);
    tick();
    checkOutput("cool_alarm", alarm, 0);
    checkOutput("cool_led", led, 8'hC0);

    // Threshold writes
    writeThr(3'd5, 12'd3700);
    feedFour(3680, 3680, 3680, 3680);
    tick();
    tick();
    checkOutput("thrw_level", level, 1);
    checkOutput("thrw_led", led, 8'hE0);
    writeThr(3'd7, 12'hFFF);
    feedFour(3680, 3680, 3680, 3680);
    tick();
    tick();
    checkOutput("thr_idx7_ignored", level, 1);
    feedFour(3690, 3690, 3690, 3690);
    writeThr(3'd4, 12'd3700);
    checkOutput("thr_coincident_old", level, 1);
    feedFour(3690, 3690, 3690, 3690);
    tick();
    checkOutput("thr_new_used", level, 2);

    // Reset mid-average clears the accumulator and restores the table
    applyStimulus(3500);
    applyStimulus(3500);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst2_level", level, 0);
    checkOutput("rst2_led", led, 8'hC0);
    checkOutput("rst2_avg", avg_out, 0);
    applyStimulus(3600);
    applyStimulus(3600);
    applyStimulus(3600);
    tick();
    tick();
    checkOutput("rst2_partial_avg", avg_out, 0);
    checkOutput("rst2_partial_level", level, 0);
    applyStimulus(3600);
    checkOutput("rst2_avg_full", avg_out, 3600);
    tick();
    checkOutput("rst2_level3", level, 3);
    feedFour(3680, 3680, 3680, 3680);
    tick();
    checkOutput("rst2_table_restored", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
